// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, RGB332 field layout and colour constants.
package vga_pkg;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

  localparam int unsigned CountWidth = 10;
  localparam int unsigned MaxTotal   = 1 << CountWidth;

  localparam int unsigned RWidth   = 3;
  localparam int unsigned GWidth   = 3;
  localparam int unsigned BWidth   = 2;
  localparam int unsigned RgbWidth = RWidth + GWidth + BWidth;

  localparam logic [RgbWidth-1:0] RgbBlack     = 8'h00;
  localparam logic [RgbWidth-1:0] BlankDefault = RgbBlack;

  typedef struct packed {
    logic [RWidth-1:0] r;
    logic [GWidth-1:0] g;
    logic [BWidth-1:0] b;
  } rgb332_t;

endpackage

// File: rtl/vga_timing.sv
// Pixel strobe, horizontal/vertical counters, raw active-low syncs and end-of-frame pulse.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp
) (
  input  logic       clk50M,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       active,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       endofframe
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (HTotal > MaxTotal || VTotal > MaxTotal) begin : g_bad_total
    $error("vga_timing: H_TOTAL/V_TOTAL must not exceed 1024");
  end

  localparam logic [9:0] HLast       = 10'(HTotal - 1);
  localparam logic [9:0] VLast       = 10'(VTotal - 1);
  localparam logic [9:0] HActiveEnd  = 10'(H_ACTIVE);
  localparam logic [9:0] VActiveEnd  = 10'(V_ACTIVE);
  localparam logic [9:0] HSyncStart  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncEnd    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VSyncStart  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncEnd    = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       pix_q;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       h_wrap;

  always_comb begin
    h_wrap = (h_q == HLast);
    h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == VLast) ? 10'd0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      pix_q <= 1'b0;
      h_q   <= 10'd0;
      v_q   <= 10'd0;
    end else begin
      pix_q <= ~pix_q;
      if (pix_q) begin
        h_q <= h_d;
        v_q <= v_d;
      end
    end
  end

  assign pix_en     = pix_q;
  assign hcount     = h_q;
  assign vcount     = v_q;
  assign active     = (h_q < HActiveEnd) && (v_q < VActiveEnd);
  assign hs_raw     = !((h_q >= HSyncStart) && (h_q < HSyncEnd));
  assign vs_raw     = !((v_q >= VSyncStart) && (v_q < VSyncEnd));
  assign endofframe = pix_q && (h_q == HLast) && (v_q == VLast);

endmodule

// File: rtl/vga_compositor.sv
// Layered VGA compositor: priority mux of masked layers over a background, registered RGB332 out.
module vga_compositor
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DefHActive,
  parameter int unsigned H_FP       = DefHFp,
  parameter int unsigned H_SYNC     = DefHSync,
  parameter int unsigned H_BP       = DefHBp,
  parameter int unsigned V_ACTIVE   = DefVActive,
  parameter int unsigned V_FP       = DefVFp,
  parameter int unsigned V_SYNC     = DefVSync,
  parameter int unsigned V_BP       = DefVBp,
  parameter int unsigned NUM_LAYERS = 4,
  parameter logic [7:0]  BLANK_RGB  = BlankDefault
) (
  input  logic                    clk50M,
  input  logic                    reset,
  input  logic [NUM_LAYERS-1:0]   layer_on,
  input  logic [8*NUM_LAYERS-1:0] layer_rgb,
  input  logic [7:0]              bg_rgb,
  input  logic [NUM_LAYERS-1:0]   layer_mask,
  output logic [9:0]              xpixel,
  output logic [9:0]              ypixel,
  output logic                    pix_en,
  output logic [2:0]              red,
  output logic [2:0]              green,
  output logic [1:0]              blue,
  output logic                    HS,
  output logic                    VS,
  output logic                    endofframe
);

  if (NUM_LAYERS < 1 || NUM_LAYERS > 8) begin : g_bad_layers
    $error("vga_compositor: NUM_LAYERS must be in 1..8");
  end

  logic       active;
  logic       hs_raw;
  logic       vs_raw;
  logic [9:0] hcount;
  logic [9:0] vcount;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk50M     (clk50M),
    .reset      (reset),
    .pix_en     (pix_en),
    .hcount     (hcount),
    .vcount     (vcount),
    .active     (active),
    .hs_raw     (hs_raw),
    .vs_raw     (vs_raw),
    .endofframe (endofframe)
  );

  assign xpixel = hcount;
  assign ypixel = vcount;

  logic [NUM_LAYERS-1:0] mask_q;
  rgb332_t               sel;
  rgb332_t               pix_q;
  logic                  hs_q;
  logic                  vs_q;
  logic                  found;

  // Lowest-index covering layer wins; blanking overrides everything.
  always_comb begin
    sel   = rgb332_t'(bg_rgb);
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (!found && layer_on[i] && mask_q[i]) begin
        sel   = rgb332_t'(layer_rgb[8*i +: 8]);
        found = 1'b1;
      end
    end
    if (!active) begin
      sel = rgb332_t'(BLANK_RGB);
    end
  end

  // The mask shadow only moves at the frame boundary so a frame is never torn.
  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      mask_q <= '1;
      pix_q  <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
    end else begin
      if (endofframe) begin
        mask_q <= layer_mask;
      end
      if (pix_en) begin
        pix_q <= sel;
        hs_q  <= hs_raw;
        vs_q  <= vs_raw;
      end
    end
  end

  assign red   = pix_q.r;
  assign green = pix_q.g;
  assign blue  = pix_q.b;
  assign HS    = hs_q;
  assign VS    = vs_q;

endmodule

// File: tb/tb_vga_compositor.sv
// Self-checking bench for vga_compositor using a reduced raster and a pixel-index reference model.
module tb_vga_compositor;

  localparam int HA = 16, HFP = 2, HSY = 4, HBP = 3;
  localparam int VA = 10, VFP = 1, VSY = 2, VBP = 2;
  localparam int HT = HA + HFP + HSY + HBP;  // 25
  localparam int VT = VA + VFP + VSY + VBP;  // 15
  localparam int FT = HT * VT;               // 375 pixels per frame
  localparam logic [7:0] BLANK = 8'h25;

  logic        clk50M = 1'b0;
  logic        reset  = 1'b1;
  logic [3:0]  layer_on   = '0;
  logic [31:0] layer_rgb  = '0;
  logic [7:0]  bg_rgb     = '0;
  logic [3:0]  layer_mask = 4'hF;
  logic [9:0]  xpixel, ypixel;
  logic        pix_en;
  logic [2:0]  red, green;
  logic [1:0]  blue;
  logic        HS, VS, endofframe;

  vga_compositor #(
    .H_ACTIVE   (HA),
    .H_FP       (HFP),
    .H_SYNC     (HSY),
    .H_BP       (HBP),
    .V_ACTIVE   (VA),
    .V_FP       (VFP),
    .V_SYNC     (VSY),
    .V_BP       (VBP),
    .NUM_LAYERS (4),
    .BLANK_RGB  (BLANK)
  ) dut (
    .clk50M     (clk50M),
    .reset      (reset),
    .layer_on   (layer_on),
    .layer_rgb  (layer_rgb),
    .bg_rgb     (bg_rgb),
    .layer_mask (layer_mask),
    .xpixel     (xpixel),
    .ypixel     (ypixel),
    .pix_en     (pix_en),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .HS         (HS),
    .VS         (VS),
    .endofframe (endofframe)
  );

  always #5 clk50M = ~clk50M;

  int checks = 0;
  int errors = 0;

  // Model state: k counts clk50M edges since reset release; pixel index is derived from it.
  int         k;
  logic [3:0] shadow_m;
  logic [7:0] exp_rgb;
  logic       exp_hs, exp_vs;
  logic       last_active;
  int         last_h, last_v;

  typedef struct {
    logic [3:0]  on;
    logic [31:0] rgb;
    logic [7:0]  bg;
    logic [7:0]  exp;
  } vec_t;

  function automatic logic [7:0] ref_colour(int h, int v, logic [3:0] on, logic [31:0] rgb,
                                            logic [7:0] bg, logic [3:0] sh);
    if (!(h < HA && v < VA)) return BLANK;
    for (int i = 0; i < 4; i++) begin
      if (on[i] && sh[i]) return rgb[8*i +: 8];
    end
    return bg;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_init();
    k        = 0;
    shadow_m = 4'hF;
    exp_rgb  = 8'h00;
    exp_hs   = 1'b1;
    exp_vs   = 1'b1;
    last_active = 1'b0;
    last_h   = 0;
    last_v   = 0;
  endtask

  // One clk50M edge: update the model from the inputs present at the edge, then check everything.
  task automatic step();
    int q, n, h, v;
    @(posedge clk50M);
    k++;
    if (k % 2 == 0) begin
      q = k / 2 - 1;
      h = q % HT;
      v = (q / HT) % VT;
      exp_rgb = ref_colour(h, v, layer_on, layer_rgb, bg_rgb, shadow_m);
      exp_hs  = !(h >= HA + HFP && h < HA + HFP + HSY);
      exp_vs  = !(v >= VA + VFP && v < VA + VFP + VSY);
      last_active = (h < HA && v < VA);
      last_h = h;
      last_v = v;
      if (q % FT == FT - 1) shadow_m = layer_mask;
    end
    #1;
    n = k / 2;
    chk("pix_en", int'(pix_en), (k % 2 == 1) ? 1 : 0);
    chk("xpixel", int'(xpixel), n % HT);
    chk("ypixel", int'(ypixel), (n / HT) % VT);
    chk("endofframe", int'(endofframe), ((k % 2 == 1) && (n % FT == FT - 1)) ? 1 : 0);
    chk("rgb", int'({red, green, blue}), int'(exp_rgb));
    chk("HS", int'(HS), int'(exp_hs));
    chk("VS", int'(VS), int'(exp_vs));
  endtask

  task automatic wait_active_pix(int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(k % 2 == 0 && last_active) && n < budget);
    if (!(k % 2 == 0 && last_active)) chk("timeout_active", 0, 1);
  endtask

  task automatic wait_eof(int budget, output int steps);
    steps = 0;
    do begin
      step();
      steps++;
    end while (!endofframe && steps < budget);
    if (!endofframe) chk("timeout_eof", 0, 1);
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_pix_en"}, int'(pix_en), 0);
    chk({tag, "_xpixel"}, int'(xpixel), 0);
    chk({tag, "_ypixel"}, int'(ypixel), 0);
    chk({tag, "_rgb"}, int'({red, green, blue}), 0);
    chk({tag, "_HS"}, int'(HS), 1);
    chk({tag, "_VS"}, int'(VS), 1);
    chk({tag, "_eof"}, int'(endofframe), 0);
  endtask

  initial begin
    vec_t vecs[8];
    int   hs_low, vs_low, eof_cnt, s, k1, n;

    // Layer colours: L0=03, L1=E0, L2=1C, L3=49.
    vecs[0] = '{4'b0110, 32'h491CE003, 8'h92, 8'hE0};
    vecs[1] = '{4'b0000, 32'h491CE003, 8'h92, 8'h92};
    vecs[2] = '{4'b0001, 32'h491CE003, 8'h92, 8'h03};
    vecs[3] = '{4'b1000, 32'h491CE003, 8'h92, 8'h49};
    vecs[4] = '{4'b1100, 32'h491CE003, 8'h92, 8'h1C};
    vecs[5] = '{4'b1111, 32'h491CE003, 8'h92, 8'h03};
    vecs[6] = '{4'b0100, 32'h491CE003, 8'h92, 8'h1C};
    vecs[7] = '{4'b1010, 32'h491CE003, 8'h6D, 8'hE0};

    repeat (3) @(negedge clk50M);
    #1;
    check_reset_state("reset");
    @(negedge clk50M);
    reset = 1'b0;
    model_init();

    foreach (vecs[i]) begin
      layer_on  = vecs[i].on;
      layer_rgb = vecs[i].rgb;
      bg_rgb    = vecs[i].bg;
      wait_active_pix(4 * HT);
      chk("table", int'({red, green, blue}), int'(vecs[i].exp));
    end

    // Randomized traffic against the model, with occasional mask changes.
    for (int i = 0; i < 2 * FT + 60; i++) begin
      layer_on  = 4'($urandom);
      layer_rgb = $urandom;
      bg_rgb    = 8'($urandom);
      if (i % 97 == 0) layer_mask = 4'($urandom);
      step();
    end

    // Free-run one whole frame period: sync widths and a single end-of-frame pulse.
    layer_mask = 4'hF;
    hs_low = 0; vs_low = 0; eof_cnt = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      step();
      if (!HS) hs_low++;
      if (!VS) vs_low++;
      if (endofframe) eof_cnt++;
    end
    chk("hs_low_clks", hs_low, 2 * HSY * VT);
    chk("vs_low_clks", vs_low, 2 * VSY * HT);
    chk("eof_per_frame", eof_cnt, 1);

    wait_eof(2 * FT + 4, s);
    k1 = k;
    wait_eof(2 * FT + 4, s);
    chk("eof_period", k - k1, 2 * FT);

    // Mask cleared mid-frame must not show until the following frame.
    layer_on   = 4'b0110;
    layer_rgb  = 32'h491CE003;
    bg_rgb     = 8'h92;
    layer_mask = 4'hF;
    wait_eof(2 * FT + 4, s);
    step();
    repeat (40) step();
    layer_mask = 4'b1101;
    wait_active_pix(2 * FT);
    chk("mask_same_frame", int'({red, green, blue}), 8'hE0);
    wait_eof(2 * FT + 4, s);
    step();
    wait_active_pix(2 * FT);
    chk("mask_next_frame", int'({red, green, blue}), 8'h1C);

    // First blanked column with layers on, then background with no layers.
    n = 0;
    do begin
      step();
      n++;
    end while (!(k % 2 == 0 && last_h == HA && last_v < VA) && n < 2 * FT);
    chk("blank_col", int'({red, green, blue}), int'(BLANK));
    layer_on = 4'b0000;
    bg_rgb   = 8'h5A;
    wait_active_pix(2 * FT);
    chk("bg_only", int'({red, green, blue}), 8'h5A);

    // Reset in the middle of a frame.
    n = 0;
    while (((k / 2) / HT) % VT != 5 && n < 2 * FT) begin
      step();
      n++;
    end
    @(negedge clk50M);
    reset = 1'b1;
    #1;
    check_reset_state("midreset");
    @(negedge clk50M);
    reset = 1'b0;
    model_init();
    // endofframe is visible in the clk50M cycle ending at edge 2*FT after release.
    wait_eof(2 * FT + 4, s);
    chk("eof_after_reset", s, 2 * FT - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_compositor.md
VGA_COMPOSITOR -- requirements
Module: vga_compositor

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48: horizontal front porch, sync and back porch in pixels.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33: vertical porch and sync in lines.
REQ-005 Parameter NUM_LAYERS, default 4, range 1..8; number of drawable layers.
REQ-006 Parameter BLANK_RGB, default 8'h00, RGB332 colour driven during blanking.
REQ-007 clk50M  in  1  system clock.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 layer_on  in  NUM_LAYERS  per-layer coverage for the current xpixel/ypixel.
REQ-010 layer_rgb  in  8*NUM_LAYERS  per-layer RGB332 colour; layer i at bits [8i+7:8i].
REQ-011 bg_rgb  in  8  background colour when no enabled layer covers the pixel.
REQ-012 layer_mask  in  NUM_LAYERS  layer enables; shadowed per frame.
REQ-013 xpixel, ypixel  out  10 each  current active-area coordinate, origin at first visible pixel.
REQ-014 pix_en  out  1  25 MHz pixel strobe.
REQ-015 red, green  out  3 each; blue  out  2  registered pixel colour.
REQ-016 HS, VS  out  1 each  active-low syncs, aligned with colour.
REQ-017 endofframe  out  1  one-clk50M pulse at the last pixel of each frame.

Function
REQ-018 pix_en toggles every clk50M edge; hcount/vcount advance only on edges with pix_en=1.
REQ-019 hcount wraps H_TOTAL-1 -> 0 (H_TOTAL = sum of H params); vcount increments on hcount wrap and wraps V_TOTAL-1 -> 0.
REQ-020 xpixel=hcount, ypixel=vcount, combinational; active = (hcount<H_ACTIVE) && (vcount<V_ACTIVE).
REQ-021 Internal HS low when hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); VS likewise on vcount with V params.
REQ-022 Colour select: inactive -> BLANK_RGB; else lowest index i with layer_on[i] && mask_shadow[i] -> layer i colour; else bg_rgb.
REQ-023 Selected colour, HS and VS registered on pix_en edges: exactly one pixel latency from xpixel/ypixel to red/green/blue; HS/VS delayed identically.
REQ-024 endofframe=1 for the single clk50M cycle where pix_en=1, hcount=H_TOTAL-1, vcount=V_TOTAL-1.
REQ-025 mask_shadow loads layer_mask only in the endofframe cycle; mid-frame mask changes invisible until next frame.
REQ-026 NUM_LAYERS outside 1..8 or H_TOTAL/V_TOTAL >1024 are elaboration errors.

Reset
REQ-027 Reset forces pix_en toggle 0, hcount=vcount=0, colour outputs 0, HS=VS=1, mask_shadow all ones, endofframe 0.
REQ-028 Reset asserted mid-frame takes effect immediately; after release the first pix_en edge starts pixel (0,0).

Structure
REQ-029 Package vga_pkg holds default timing constants, RGB332 field widths and colour constants (black, BLANK default).
REQ-030 Sub-module vga_timing (pixel strobe, counters, raw syncs, endofframe); compositor mux and output registers in top.

Verification
REQ-031 Reset release -> outputs 0, HS=VS=1; pix_en high every second clk50M cycle.
REQ-032 Defaults free-run -> HS low 96 pixels (192 clk50M) per 800-pixel line; VS low 2 lines; endofframe every 840000 clk50M.
REQ-033 layer_on=4'b0110, colours L1=8'hE0, L2=8'h1C, mask=4'hF, active -> output 8'hE0 one pixel later.
REQ-034 Clear mask bit1 mid-frame -> L1 still shown to frame end; next frame shows 8'h1C.
REQ-035 Pixel at hcount=640 with layers on -> BLANK_RGB; layer_on=0 active -> bg_rgb.
REQ-036 Reset pulse at vcount=200 -> counters 0 immediately, next endofframe exactly 840000 clk50M after release.
